// File: rtl/block_game_pkg.sv
// Shared definitions for the falling-block hit judge: FSM encoding,
// row geometry and the BCD score ceiling.
package block_game_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PLAY = 2'd1,
    ST_OVER = 2'd2
  } state_e;

  localparam int LANE_W = 2;
  localparam int ROW_W  = 8;

  localparam logic [15:0] BCD_MAX = 16'h9999;

endpackage

// File: rtl/bcd_score_counter.sv
// Four-digit BCD score register. Adds 0..4 per cycle with decimal carry
// and pins at 9999 instead of wrapping.
module bcd_score_counter
  import block_game_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        clear_i,
  input  logic [2:0]  inc_i,
  output logic [15:0] score_o
);

  logic [15:0] score_q;
  logic [15:0] score_d;
  logic [2:0]  carry;
  logic [4:0]  dsum;

  always_comb begin
    score_d = score_q;
    carry   = inc_i;
    dsum    = '0;
    for (int d = 0; d < 4; d++) begin
      dsum = {1'b0, score_q[d*4 +: 4]} + {2'b00, carry};
      if (dsum > 5'd9) begin
        score_d[d*4 +: 4] = 4'(dsum - 5'd10);
        carry             = 3'd1;
      end else begin
        score_d[d*4 +: 4] = dsum[3:0];
        carry             = 3'd0;
      end
    end
    // a carry out of the thousands digit means the true sum exceeds 9999
    if (carry != 3'd0) score_d = BCD_MAX;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      score_q <= '0;
    end else if (clear_i) begin
      score_q <= '0;
    end else begin
      score_q <= score_d;
    end
  end

  assign score_o = score_q;

endmodule

// File: rtl/block_hit_judge.sv
// Judges key presses against the bottom row of the falling-block field,
// tracking lives, per-lane hits and a BCD score across IDLE/PLAY/OVER.
module block_hit_judge
  import block_game_pkg::*;
#(
  parameter int LIVES_INIT = 3,
  parameter int LANES      = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [63:0]      Disp_num,
  input  logic             EN,
  input  logic [LANES-1:0] key,
  output logic [15:0]      score,
  output logic [1:0]       lives,
  output logic             game_over,
  output logic             miss,
  output logic [ROW_W-1:0] row_mask
);

  localparam logic [1:0] LIVES_LOAD = 2'(LIVES_INIT);

  state_e           state_q;
  logic [1:0]       lives_q;
  logic [LANES-1:0] hit_mask_q;
  logic [LANES-1:0] hit_mask_d;
  logic [ROW_W-1:0] row_q;
  logic             miss_q;

  logic [LANES-1:0] win_occ;
  logic [LANES-1:0] prev_occ;
  logic [LANES-1:0] base_mask;
  logic [LANES-1:0] hit_vld;
  logic [LANES-1:0] key_bad;
  logic             play;
  logic             en_miss;
  logic             lose_life;
  logic [2:0]       hit_cnt;
  logic             unused_upper_rows;

  assign unused_upper_rows = ^Disp_num[63:ROW_W];

  always_comb begin
    win_occ  = '0;
    prev_occ = '0;
    row_mask = '0;
    for (int i = 0; i < LANES; i++) begin
      win_occ[i]  = |Disp_num[i*LANE_W +: LANE_W];
      prev_occ[i] = |row_q[i*LANE_W +: LANE_W];
      row_mask[i*LANE_W +: LANE_W] = hit_mask_q[i] ? '0 : Disp_num[i*LANE_W +: LANE_W];
    end
  end

  // On EN the window already holds the new row, so a same-cycle key is judged
  // against a clean mask while the miss check looks at the departed row_q.
  always_comb begin
    play       = (state_q == ST_PLAY) && !start;
    base_mask  = EN ? '0 : hit_mask_q;
    hit_vld    = play ? (key & win_occ & ~base_mask) : '0;
    key_bad    = play ? (key & ~(win_occ & ~base_mask)) : '0;
    en_miss    = play && EN && |(prev_occ & ~hit_mask_q);
    lose_life  = (|key_bad || en_miss) && (lives_q != 2'd0);
    hit_mask_d = play ? (base_mask | hit_vld) : hit_mask_q;
    hit_cnt    = '0;
    for (int i = 0; i < LANES; i++) hit_cnt = hit_cnt + {2'b00, hit_vld[i]};
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      lives_q    <= LIVES_LOAD;
      hit_mask_q <= '0;
      row_q      <= '0;
      miss_q     <= 1'b0;
    end else begin
      row_q  <= Disp_num[ROW_W-1:0];
      miss_q <= lose_life;
      if (start) begin
        state_q    <= ST_PLAY;
        lives_q    <= LIVES_LOAD;
        hit_mask_q <= '0;
      end else if (state_q == ST_PLAY) begin
        hit_mask_q <= hit_mask_d;
        if (lose_life) lives_q <= lives_q - 2'd1;
        if (lives_q == 2'd0) state_q <= ST_OVER;
      end
    end
  end

  bcd_score_counter u_score (
    .clk     (clk),
    .rst     (rst),
    .clear_i (start),
    .inc_i   (hit_cnt),
    .score_o (score)
  );

  assign lives     = lives_q;
  assign miss      = miss_q;
  assign game_over = (state_q == ST_OVER);

endmodule

// File: tb/tb_block_hit_judge.sv
// Directed bench for block_hit_judge with hand-computed expectations.
module tb_block_hit_judge;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [63:0] Disp_num;
  logic        EN;
  logic [3:0]  key;
  logic [15:0] score;
  logic [1:0]  lives;
  logic        game_over;
  logic        miss;
  logic [7:0]  row_mask;

  int n_tests = 0;
  int n_fail  = 0;

  block_hit_judge #(.LIVES_INIT(3), .LANES(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .Disp_num  (Disp_num),
    .EN        (EN),
    .key       (key),
    .score     (score),
    .lives     (lives),
    .game_over (game_over),
    .miss      (miss),
    .row_mask  (row_mask)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [7:0] row, input logic en, input logic [3:0] k);
    Disp_num = {56'h0123_4567_89AB_CD, row};
    EN       = en;
    key      = k;
  endtask

  initial begin
    rst = 1'b0; start = 1'b0;
    drive(8'h00, 1'b0, 4'b0000);
    step(); step();
    chk("rst_score", score, 16'h0000);
    chk("rst_lives", lives, 2'd3);
    chk("rst_over", game_over, 1'b0);
    chk("rst_miss", miss, 1'b0);
    drive(8'h41, 1'b0, 4'b0000);
    #1 chk("rst_rowmask", row_mask, 8'h41);

    // IDLE ignores keys
    rst = 1'b1;
    drive(8'h01, 1'b0, 4'b0011); step();
    chk("idle_score", score, 16'h0000);
    chk("idle_miss", miss, 1'b0);
    chk("idle_lives", lives, 2'd3);

    start = 1'b1; drive(8'h01, 1'b0, 4'b0000); step(); start = 1'b0;
    chk("start_over", game_over, 1'b0);

    drive(8'h01, 1'b0, 4'b0001); step();
    chk("hit_score", score, 16'h0001);
    chk("hit_rowmask", row_mask, 8'h00);
    chk("hit_lives", lives, 2'd3);
    chk("hit_nomiss", miss, 1'b0);

    drive(8'h01, 1'b0, 4'b0001); step();
    chk("rehit_miss", miss, 1'b1);
    chk("rehit_lives", lives, 2'd2);
    chk("rehit_score", score, 16'h0001);

    drive(8'h00, 1'b1, 4'b0000); step();
    chk("en_allhit_miss", miss, 1'b0);
    chk("en_allhit_lives", lives, 2'd2);

    drive(8'h41, 1'b0, 4'b0000); step();
    chk("mask_cleared", row_mask, 8'h41);

    drive(8'h00, 1'b1, 4'b0000); step();
    chk("en_unhit_miss", miss, 1'b1);
    chk("en_unhit_lives", lives, 2'd1);
    drive(8'h00, 1'b0, 4'b0000); step();
    chk("miss_pulse_end", miss, 1'b0);

    // three wrong-lane presses exhaust lives
    start = 1'b1; step(); start = 1'b0;
    chk("restart_lives", lives, 2'd3);
    drive(8'h01, 1'b0, 4'b0010); step();
    chk("bad1_lives", lives, 2'd2);
    chk("bad1_miss", miss, 1'b1);
    chk("bad1_score", score, 16'h0000);
    step();
    chk("bad2_lives", lives, 2'd1);
    step();
    chk("bad3_lives", lives, 2'd0);
    chk("bad3_notover", game_over, 1'b0);
    drive(8'h01, 1'b0, 4'b0000); step();
    chk("over_flag", game_over, 1'b1);
    drive(8'h01, 1'b0, 4'b0010); step();
    chk("over_ign_lives", lives, 2'd0);
    chk("over_ign_miss", miss, 1'b0);

    start = 1'b1; drive(8'h00, 1'b0, 4'b0000); step(); start = 1'b0;
    chk("over_restart_lives", lives, 2'd3);
    chk("over_restart_flag", game_over, 1'b0);
    chk("over_restart_score", score, 16'h0000);

    // BCD carry and saturation
    drive(8'h00, 1'b0, 4'b0000); step();
    for (int i = 0; i < 24; i++) begin
      drive(8'h55, 1'b1, 4'b1111); step();
    end
    chk("bcd_96", score, 16'h0096);
    drive(8'h00, 1'b1, 4'b0000); step();
    drive(8'h55, 1'b0, 4'b0111); step();
    chk("bcd_99", score, 16'h0099);
    drive(8'h55, 1'b0, 4'b1000); step();
    chk("bcd_100", score, 16'h0100);
    for (int i = 0; i < 2474; i++) begin
      drive(8'h55, 1'b1, 4'b1111); step();
    end
    chk("bcd_9996", score, 16'h9996);
    drive(8'h00, 1'b1, 4'b0000); step();
    drive(8'h41, 1'b0, 4'b1001); step();
    chk("bcd_9998", score, 16'h9998);
    drive(8'h41, 1'b1, 4'b1001); step();
    chk("bcd_sat", score, 16'h9999);
    chk("bcd_lives", lives, 2'd3);

    // key together with EN credits the new row
    start = 1'b1; drive(8'h41, 1'b0, 4'b0000); step(); start = 1'b0;
    chk("restart_score", score, 16'h0000);
    drive(8'h00, 1'b0, 4'b0000); step();
    drive(8'h01, 1'b1, 4'b0001); step();
    chk("keyen_score", score, 16'h0001);
    chk("keyen_rowmask", row_mask, 8'h00);
    chk("keyen_miss", miss, 1'b0);
    drive(8'h00, 1'b1, 4'b0000); step();
    chk("keyen_next_miss", miss, 1'b0);
    chk("keyen_next_lives", lives, 2'd3);

    // simultaneous keys: per-lane hits, at most one life lost
    drive(8'h01, 1'b0, 4'b0011); step();
    chk("multi_score", score, 16'h0002);
    chk("multi_lives", lives, 2'd2);
    chk("multi_miss", miss, 1'b1);
    drive(8'h01, 1'b0, 4'b1110); step();
    chk("allbad_lives", lives, 2'd1);
    chk("allbad_score", score, 16'h0002);

    // reset overrides start mid-game
    rst = 1'b0; start = 1'b1; drive(8'h41, 1'b0, 4'b0000); step();
    rst = 1'b1; start = 1'b0;
    chk("rststart_score", score, 16'h0000);
    chk("rststart_lives", lives, 2'd3);
    chk("rststart_miss", miss, 1'b0);
    chk("rststart_over", game_over, 1'b0);
    drive(8'h01, 1'b0, 4'b0001); step();
    chk("rststart_idle", score, 16'h0000);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
